// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART sample-frame scheduler: frame layout,
// FSM encodings and the frame checksum.
package uart_tx_scheduler_pkg;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
    localparam int         FRAME_LEN      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } sched_state_t;

    function automatic logic [7:0] frame_checksum(input logic [7:0]  header,
                                                  input logic [7:0]  ch_byte,
                                                  input logic [15:0] sample);
        return header + ch_byte + sample[15:8] + sample[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1 and
// reports the first requesting channel.
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] req,
    input  logic [2:0]      last_grant,
    output logic            valid,
    output logic [2:0]      grant
);

    localparam logic [N_CH-1:0] ONE = {{(N_CH-1){1'b0}}, 1'b1};

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        grant = 3'd0;
        for (int offset = N_CH; offset >= 1; offset--) begin
            if (((req >> ((int'(last_grant) + offset) % N_CH)) & ONE) != '0) begin
                valid = 1'b1;
                grant = 3'((int'(last_grant) + offset) % N_CH);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Collects 16-bit samples from N_CH requesters and streams each as a 5-byte
// frame (header, channel, data hi, data lo, checksum) to an external UART.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int         N_CH   = 4,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 en,
    input  logic [N_CH-1:0]      ch_req,
    input  logic [16*N_CH-1:0]   ch_data,
    output logic [N_CH-1:0]      ch_ack,
    output logic [7:0]           tx_data,
    output logic                 tx_send_en,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [2:0]           cur_ch
);

    localparam logic [2:0]      LAST_IDX = 3'(FRAME_LEN - 1);
    localparam logic [N_CH-1:0] ONE      = {{(N_CH-1){1'b0}}, 1'b1};

    sched_state_t                 state;
    logic [2:0]                   last_grant;
    logic [2:0]                   byte_idx;
    logic [FRAME_LEN-1:0][7:0]    frame;
    logic                         arb_valid;
    logic [2:0]                   arb_grant;
    logic [15:0]                  sample;
    logic [7:0]                   ch_byte;

    assign sample  = ch_data[16*arb_grant +: 16];
    assign ch_byte = {5'b0, arb_grant};

    rr_arbiter #(.N_CH(N_CH)) u_arbiter (
        .req        (ch_req),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    // busy rises on entering ARB so it covers the arbitration cycle; the frame
    // is copied into a local buffer at grant so requesters may move on freely.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            tx_send_en <= 1'b0;
            tx_data    <= 8'h00;
            ch_ack     <= '0;
            busy       <= 1'b0;
            cur_ch     <= 3'd0;
            last_grant <= 3'(N_CH - 1);
            byte_idx   <= 3'd0;
            frame      <= '0;
        end else begin
            tx_send_en <= 1'b0;
            ch_ack     <= '0;
            case (state)
                IDLE: begin
                    if (en && (|ch_req)) begin
                        busy  <= 1'b1;
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (arb_valid) begin
                        frame      <= {frame_checksum(HEADER, ch_byte, sample),
                                       sample[7:0], sample[15:8], ch_byte, HEADER};
                        ch_ack     <= ONE << arb_grant;
                        cur_ch     <= arb_grant;
                        byte_idx   <= 3'd0;
                        tx_data    <= HEADER;
                        tx_send_en <= 1'b1;
                        state      <= SEND;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (tx_done) begin
                        if (byte_idx < LAST_IDX) begin
                            byte_idx   <= byte_idx + 3'd1;
                            tx_data    <= frame[byte_idx + 3'd1];
                            tx_send_en <= 1'b1;
                            state      <= SEND;
                        end else begin
                            busy       <= 1'b0;
                            last_grant <= cur_ch;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of sample requesters (2..8).
REQ-002 SHALL have parameter HEADER, default 8'hA5, frame start byte.
REQ-003 SHALL have port Clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  when high, new frames may start.
REQ-006 SHALL have port ch_req  input  N_CH  per-channel level request, held until acked.
REQ-007 SHALL have port ch_data  input  16*N_CH  sample of channel i on bits [16i+15:16i].
REQ-008 SHALL have port ch_ack  output  N_CH  one-cycle pulse when the channel's sample is latched.
REQ-009 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-010 SHALL have port tx_send_en  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 SHALL have port tx_done  input  1  one-cycle pulse from the UART after the stop bit.
REQ-012 SHALL have port busy  output  1  high from grant until the last tx_done of a frame.
REQ-013 SHALL have port cur_ch  output  3  index of the channel being sent; holds last value when idle.

Function
REQ-014 SHALL run FSM states IDLE, ARB, SEND, WAIT.
REQ-015 IDLE: if en=1 and any ch_req bit is set, go to ARB on the next edge; otherwise stay in IDLE.
REQ-016 ARB: pick a channel round-robin, searching upward from (last_grant+1) mod N_CH; one cycle.
REQ-017 ARB: in the same edge, latch the frame (HEADER, {5'b0,ch}, data[15:8], data[7:0], checksum), pulse ch_ack[ch], set cur_ch, set busy, clear the byte index, and go to SEND.
REQ-018 Checksum SHALL be (HEADER + ch byte + data hi + data lo) mod 256, truncated to 8 bits.
REQ-019 SEND: hold tx_send_en=1 for exactly one cycle, with tx_data = frame byte[index] stable from that cycle until the next SEND; then go to WAIT.
REQ-020 WAIT: on tx_done with index<4, increment the index and go to SEND; with index=4, clear busy, update last_grant, and go to IDLE.
REQ-021 A tx_done pulse outside WAIT SHALL be ignored.
REQ-022 tx_send_en SHALL never be asserted while a byte is outstanding; at most one send per tx_done.
REQ-023 Frame latency: first tx_send_en 2 cycles after ch_req rises in IDLE; next tx_send_en 1 cycle after each tx_done.
REQ-024 Changes to ch_data or ch_req after ack SHALL NOT alter the frame in flight.
REQ-025 Deasserting en mid-frame SHALL let the current frame complete; no new frame starts while en=0.
REQ-026 If a request drops before ARB, the grant SHALL go only to a channel still requesting in the ARB cycle; if none are requesting, return to IDLE with no ack.
REQ-027 Back-to-back: after a frame ends, a pending request SHALL enter ARB on the next edge.

Reset
REQ-028 Reset_n low SHALL asynchronously force IDLE with tx_send_en=0, tx_data=8'h00, ch_ack=0, busy=0, cur_ch=0, last_grant=N_CH-1 (channel 0 has first priority), and index 0.
REQ-029 Reset mid-frame SHALL abandon the frame; after release, no byte is resent until a new request arrives.

Structure
REQ-030 HEADER, the frame length (5), and the FSM state encodings SHALL live in a shared package used by the scheduler and its bench.
REQ-031 The round-robin picker SHALL be one combinational sub-module, rr_arbiter (inputs req and last_grant; outputs valid and grant index).
REQ-032 The UART transmitter SHALL be instantiated beside the block, not inside it.

Verification
REQ-033 ch_req=4'b0100, ch2 data=16'h1234, tx_done 1 cycle after each send -> tx_data sequence A5,02,12,34,ED; one ch_ack[2] pulse.
REQ-034 All four channels requesting from reset -> frames sent in order ch0, ch1, ch2, ch3, each 5 bytes, busy low 1 cycle between frames.
REQ-035 last_grant=1, requests on ch0 and ch3 -> ch3 granted first, then ch0.
REQ-036 tx_done pulsed during IDLE and SEND -> no extra tx_send_en and no index advance.
REQ-037 Reset_n low after byte 2 of a frame -> all outputs at reset values immediately; after release with no requests, tx_send_en stays 0.
REQ-038 en=0 with ch_req=4'b0001 -> no ack; en dropped mid-frame -> remaining bytes still sent, then IDLE.
